// File: rtl/core_run_controller.sv
// core_run_controller: run/IRQ/flush sequencer driving pipeline enable, flush and PC-override.
// Optional cycle watchdog is compiled in when CTRL_WATCHDOG_EN is defined.
module core_run_controller #(
  parameter int NUM_IRQ       = 4,
  parameter int ADDR_W        = 32,
  parameter int VEC_STRIDE    = 4,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int WDOG_LIMIT    = 2**20,
  localparam int IDX_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         ctrl_i,
  input  logic               end_condition_i,
  input  logic               all_ready_i,
  input  logic               drain_done_i,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               irq_done_i,
  input  logic [ADDR_W-1:0]  irq_vec_base_i,
  output logic               irq_grant_o,
  output logic [IDX_W-1:0]   irq_id_o,
  output logic [ADDR_W-1:0]  irq_addr_o,
  output logic               pc_override_o,
  output logic               flush_partial_o,
  output logic               flush_full_o,
  output logic               enable_design_o,
  output logic               program_finished_o,
  output logic [2:0]         state_o,
  output logic               drain_timeout_o,
  output logic               wdog_expired_o
);
  localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HANDLE = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic               drain_to_q, drain_to_d;
  logic               wdog_exp_q, wdog_exp_d;
  logic               grant_q, grant_d;
  logic [IDX_W-1:0]   id_q, id_d, grant_idx;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               start, reset_req, force_reset, wdog_hit;

  assign start       = ctrl_i[0];
  assign reset_req   = ctrl_i[1];
  assign force_reset = ctrl_i[2];

  // Fixed priority: lowest pending index wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = IDX_W'(i);
    end
  end

`ifdef CTRL_WATCHDOG_EN
  localparam int WCNT_W = $clog2(WDOG_LIMIT + 1);
  logic [WCNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              run_active;

  assign run_active = state_q inside {ST_RUN, ST_DRAIN, ST_HANDLE};
  assign wdog_hit   = run_active && (wdog_cnt_q == WCNT_W'(WDOG_LIMIT - 1));

  always_comb begin
    wdog_cnt_d = '0;
    if (run_active && !force_reset) wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_cnt_q <= '0;
    else        wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | (irq_req_i & irq_mask_i);
    drain_cnt_d = '0;
    drain_to_d  = drain_to_q;
    wdog_exp_d  = wdog_exp_q;
    grant_d     = 1'b0;
    id_d        = id_q;
    addr_d      = addr_q;
    if (force_reset) begin
      state_d    = ST_IDLE;
      pending_d  = '0;
      drain_to_d = 1'b0;
      wdog_exp_d = 1'b0;
    end else if (reset_req && (state_q inside {ST_RUN, ST_DRAIN, ST_HANDLE, ST_DONE})) begin
      state_d = ST_FLUSH;
    end else if (wdog_hit) begin
      state_d    = ST_FLUSH;
      wdog_exp_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (|pending_q)           state_d = ST_DRAIN;
          else if (end_condition_i) state_d = ST_DONE;
        end
        ST_DRAIN: begin
          if (drain_done_i) begin
            state_d   = ST_HANDLE;
            grant_d   = 1'b1;
            id_d      = grant_idx;
            addr_d    = irq_vec_base_i + ADDR_W'(grant_idx) * ADDR_W'(VEC_STRIDE);
            pending_d = pending_d & ~(NUM_IRQ'(1) << grant_idx);
          end else if (drain_cnt_q == DCNT_W'(DRAIN_TIMEOUT - 1)) begin
            state_d    = ST_FLUSH;
            drain_to_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        ST_HANDLE: if (irq_done_i)  state_d = ST_RUN;
        ST_FLUSH:  if (all_ready_i) state_d = ST_IDLE;
        ST_DONE:   ;
        default:   state_d = ST_IDLE;
      endcase
    end
    // Anything that was queued belongs to the aborted program.
    if (state_d == ST_IDLE && state_q != ST_IDLE) pending_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      drain_cnt_q <= '0;
      drain_to_q  <= 1'b0;
      wdog_exp_q  <= 1'b0;
      grant_q     <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      drain_cnt_q <= drain_cnt_d;
      drain_to_q  <= drain_to_d;
      wdog_exp_q  <= wdog_exp_d;
      grant_q     <= grant_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
    end
  end

  assign irq_grant_o        = grant_q;
  assign pc_override_o      = grant_q;
  assign irq_id_o           = id_q;
  assign irq_addr_o         = addr_q;
  assign flush_partial_o    = (state_q == ST_DRAIN);
  assign flush_full_o       = (state_q == ST_FLUSH);
  assign enable_design_o    = (state_q != ST_IDLE);
  assign program_finished_o = (state_q == ST_DONE);
  assign state_o            = state_q;
  assign drain_timeout_o    = drain_to_q;
  assign wdog_expired_o     = wdog_exp_q;

endmodule
